noise_sequencer: RTL
====================

# noise_sequencer

Per-timestep controller for the neuron noise generator bank. It runs the bank for a fixed number of cycles on each simulation step and snapshots the resulting `noise_array`. It then streams one noise sample per neuron to the neuron-update pipeline over a valid/ready handshake. It also handles LFSR reseed requests by pulsing the bank's init line outside of active steps.

## Interface
Parameters:
- `buffer_size`, 32, width of one noise sample
- `Num_Neurons`, 16, number of generators / samples per step
- `Settle_Cycles`, 12, cycles `noise_active` is held high per step (≥1)
- `Init_Cycles`, 2, cycles `noise_init` is held high per reseed (≥1)

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `step_start`  in  1  one-cycle pulse: begin a timestep
- `reseed_req`  in  1  one-cycle pulse: reinitialise the generators
- `noise_array`  in  Num_Neurons*buffer_size  packed bank output; neuron t occupies bits [(t+1)*buffer_size-1 -: buffer_size]
- `noise_active`  out  1  drives the bank's `active` enable
- `noise_init`  out  1  drives the bank's `init`; the top level ORs it with `reset`
- `sample_out`  out  buffer_size  current noise sample
- `sample_idx`  out  max(1,$clog2(Num_Neurons))  neuron index of `sample_out`
- `sample_valid`  out  1  sample present
- `sample_ready`  in  1  consumer accepts the sample when high together with valid
- `step_done`  out  1  one-cycle pulse after the last sample is accepted
- `busy`  out  1  high whenever state ≠ IDLE
- `overrun`  out  1  sticky: `step_start` arrived while busy

## Operation
- States: IDLE, INIT, RUN, LATCH, STREAM, DONE.
- Reset: state=IDLE. Every output is 0, including `overrun`. Counters, pending flags and the snapshot register are all cleared. Reset mid-operation aborts immediately, with no `step_done`.
- IDLE transitions:
  - pending or current `reseed_req` → INIT.
  - otherwise, pending or current `step_start` → RUN.
  - If both are present in the same cycle, reseed wins and the step stays pending. The step runs immediately after INIT completes.
- INIT: `noise_init`=1 and `noise_active`=0 for exactly Init_Cycles cycles, then → IDLE.
- RUN: `noise_active`=1 for exactly Settle_Cycles cycles, counted by a down-counter of width $clog2(Settle_Cycles+1). Then → LATCH.
- LATCH: one cycle with `noise_active`=0. Captures all of `noise_array` into the snapshot register, sets idx=0, then → STREAM.
- STREAM:
  - `sample_valid`=1, `sample_out`=snapshot[idx], `sample_idx`=idx.
  - Data and idx must stay stable while valid && !ready.
  - On valid && ready: if idx=Num_Neurons-1 → DONE, else idx+1.
  - idx never wraps past Num_Neurons-1.
- DONE: `step_done`=1 for one cycle, then → IDLE.
- `step_start` while busy: the step is dropped (not queued) and `overrun` is set. `overrun` clears only on reset.
- `reseed_req` while busy: sets the reseed-pending flag, which is serviced at the next IDLE. Multiple requests collapse into one.
- `noise_init` and `noise_active` are never high in the same cycle.
- The snapshot is not disturbed by the bank during STREAM, because the bank is idle.

## Timing
- All outputs are registered.
- `step_start` sampled high at edge 0 gives RUN from cycle 1. `noise_active` is high for cycles 1..Settle_Cycles.
- LATCH occurs at cycle Settle_Cycles+1. The first `sample_valid` appears at cycle Settle_Cycles+2.
- With `sample_ready` tied high, samples occupy cycles S+2..S+N+1 (S=Settle_Cycles, N=Num_Neurons). `step_done` is at S+N+2 and `busy` drops at S+N+3.
- The earliest next step is `step_start` sampled in the cycle `busy` is low.
- Reseed from IDLE: `noise_init` is high for cycles 1..Init_Cycles, and state returns to IDLE at Init_Cycles+1.

## Test plan
- **Basic step:** reset, then `step_start`, with ready=1 and defaults.
  - `noise_active` is high for exactly 12 cycles.
  - 16 samples appear with idx 0..15, each equal to the matching `noise_array` slice at LATCH.
  - `step_done` pulses at cycle 30.
- **Backpressure:** ready toggles 1,0,0,1 during STREAM. `sample_out` and `sample_idx` stay stable while ready=0, and no sample is skipped or duplicated.
- **Simultaneous `reseed_req` and `step_start` in IDLE:**
  - `noise_init` is high for 2 cycles.
  - RUN starts the following cycle.
  - `noise_init` and `noise_active` are never high together.
- **`step_start` during STREAM:** `overrun`=1 and stays 1, and there is no extra step. A `reseed_req` during the same STREAM causes INIT right after DONE.
- **Reset asserted mid-STREAM (idx=7):** in the next cycle all outputs are 0, state is IDLE, and no `step_done` is produced. A fresh step afterwards restarts at idx 0.
- **Parameter corner, Num_Neurons=1 and Settle_Cycles=1:** `sample_idx` is 1 bit wide and always 0. `step_done` occurs at cycle 4.

Source files
------------

// File: rtl/noise_sequencer.sv
// Per-timestep controller for the neuron noise generator bank: settles the bank,
// snapshots its outputs, then streams one sample per neuron over valid/ready.
module noise_sequencer #(
  parameter int buffer_size   = 32,
  parameter int Num_Neurons   = 16,
  parameter int Settle_Cycles = 12,
  parameter int Init_Cycles   = 2
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   step_start,
  input  logic                                                   reseed_req,
  input  logic [Num_Neurons*buffer_size-1:0]                     noise_array,
  output logic                                                   noise_active,
  output logic                                                   noise_init,
  output logic [buffer_size-1:0]                                 sample_out,
  output logic [((Num_Neurons > 1) ? $clog2(Num_Neurons) : 1)-1:0] sample_idx,
  output logic                                                   sample_valid,
  input  logic                                                   sample_ready,
  output logic                                                   step_done,
  output logic                                                   busy,
  output logic                                                   overrun
);

  localparam int IDX_W  = (Num_Neurons > 1) ? $clog2(Num_Neurons) : 1;
  localparam int RUN_W  = $clog2(Settle_Cycles + 1);
  localparam int INIT_W = $clog2(Init_Cycles + 1);
  localparam int ARR_W  = Num_Neurons * buffer_size;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    RUN    = 3'd2,
    LATCH  = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [RUN_W-1:0]        run_cnt_q, run_cnt_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ARR_W-1:0]        snap_q, snap_d;
  logic                    reseed_pend_q, reseed_pend_d;
  logic                    step_pend_q, step_pend_d;
  logic                    overrun_q, overrun_d;

  logic                    noise_active_q, noise_active_d;
  logic                    noise_init_q, noise_init_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    step_done_q, step_done_d;
  logic                    busy_q, busy_d;
  logic [buffer_size-1:0]  sample_out_q, sample_out_d;
  logic [IDX_W-1:0]        sample_idx_q, sample_idx_d;

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    init_cnt_d    = init_cnt_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    reseed_pend_d = reseed_pend_q;
    step_pend_d   = step_pend_q;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        // A reseed always goes first; a coincident step stays pending behind it.
        if (reseed_pend_q || reseed_req) begin
          state_d       = INIT;
          init_cnt_d    = INIT_W'(Init_Cycles);
          reseed_pend_d = 1'b0;
          step_pend_d   = step_pend_q || step_start;
        end else if (step_pend_q || step_start) begin
          state_d     = RUN;
          run_cnt_d   = RUN_W'(Settle_Cycles);
          step_pend_d = 1'b0;
        end
      end
      INIT: begin
        if (init_cnt_q <= INIT_W'(1)) state_d = IDLE;
        else                          init_cnt_d = init_cnt_q - INIT_W'(1);
      end
      RUN: begin
        if (run_cnt_q <= RUN_W'(1)) state_d = LATCH;
        else                        run_cnt_d = run_cnt_q - RUN_W'(1);
      end
      LATCH: begin
        snap_d  = noise_array;
        idx_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (sample_ready) begin
          if (idx_q == IDX_W'(Num_Neurons - 1)) state_d = DONE;
          else                                  idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Requests seen while busy: steps are dropped and flagged, reseeds collapse.
    if (state_q != IDLE) begin
      if (step_start) overrun_d     = 1'b1;
      if (reseed_req) reseed_pend_d = 1'b1;
    end

    noise_active_d = (state_d == RUN);
    noise_init_d   = (state_d == INIT);
    sample_valid_d = (state_d == STREAM);
    step_done_d    = (state_d == DONE);
    busy_d         = (state_d != IDLE);
    sample_out_d   = '0;
    sample_idx_d   = '0;
    if (state_d == STREAM) begin
      sample_out_d = snap_d[int'(idx_d)*buffer_size +: buffer_size];
      sample_idx_d = idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      run_cnt_q      <= '0;
      init_cnt_q     <= '0;
      idx_q          <= '0;
      snap_q         <= '0;
      reseed_pend_q  <= 1'b0;
      step_pend_q    <= 1'b0;
      overrun_q      <= 1'b0;
      noise_active_q <= 1'b0;
      noise_init_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      step_done_q    <= 1'b0;
      busy_q         <= 1'b0;
      sample_out_q   <= '0;
      sample_idx_q   <= '0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      init_cnt_q     <= init_cnt_d;
      idx_q          <= idx_d;
      snap_q         <= snap_d;
      reseed_pend_q  <= reseed_pend_d;
      step_pend_q    <= step_pend_d;
      overrun_q      <= overrun_d;
      noise_active_q <= noise_active_d;
      noise_init_q   <= noise_init_d;
      sample_valid_q <= sample_valid_d;
      step_done_q    <= step_done_d;
      busy_q         <= busy_d;
      sample_out_q   <= sample_out_d;
      sample_idx_q   <= sample_idx_d;
    end
  end

  assign noise_active = noise_active_q;
  assign noise_init   = noise_init_q;
  assign sample_valid = sample_valid_q;
  assign step_done    = step_done_q;
  assign busy         = busy_q;
  assign sample_out   = sample_out_q;
  assign sample_idx   = sample_idx_q;
  assign overrun      = overrun_q;

endmodule
